// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for data_mem_ctrl: valid/ready request, registered
// response, clear command and sweep status.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              clear;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, clear,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, clear,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with sized loads/stores, fault detection,
// one-cycle registered response and a word-per-cycle clear sweep.
module data_mem_ctrl #(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 10,
  parameter int CLR_ON_RST = 1
) (
  input logic             clk,
  input logic             rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [ADDR_W-1:0] word_idx_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [1:0]        lane_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              fault_s;
  logic [3:0]        be_s;
  logic [31:0]       wlane_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       shifted_s;
  logic [31:0]       load_data_s;

  // Address decode, alignment/range fault check and store lane enables
  always_comb begin
    word_idx_s  = {2'b00, bus.req_addr[ADDR_W-1:2]};
    mem_idx_s   = word_idx_s[IDX_W-1:0];
    lane_s      = bus.req_addr[1:0];
    req_ready_s = (state_q == ST_IDLE) && !bus.clear;
    accept_s    = bus.req_valid && req_ready_s;
    fault_s     = 1'b0;
    be_s        = 4'b0000;
    wlane_s     = 32'h0000_0000;
    case (bus.req_size)
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wlane_s = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        fault_s = lane_s[0];
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        fault_s = (lane_s != 2'b00);
        be_s    = 4'b1111;
        wlane_s = bus.req_wdata;
      end
      default: begin
        fault_s = 1'b1;
      end
    endcase
    if (word_idx_s >= DEPTH_L) begin
      fault_s = 1'b1;
    end else begin
      fault_s = fault_s;
    end
  end

  // Load extraction: right-align the addressed lane, then sign/zero extend
  always_comb begin
    rd_word_s   = mem[mem_idx_s];
    shifted_s   = rd_word_s >> {lane_s, 3'b000};
    load_data_s = 32'h0000_0000;
    case (bus.req_size)
      2'b00: load_data_s = bus.req_unsigned ? {24'h000000, shifted_s[7:0]}
                                            : {{24{shifted_s[7]}}, shifted_s[7:0]};
      2'b01: load_data_s = bus.req_unsigned ? {16'h0000, shifted_s[15:0]}
                                            : {{16{shifted_s[15]}}, shifted_s[15:0]};
      2'b10: load_data_s = rd_word_s;
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Next-state: sweep sequencing and response capture
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = RST_STATE;
        clr_idx_d = '0;
      end
    endcase
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fault_s;
      rsp_rdata_d = (fault_s || bus.req_we) ? 32'h0000_0000 : load_data_s;
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RST_STATE;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Storage array: the sweep has priority; stores touch only enabled lanes
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= 32'h0000_0000;
    end else if (accept_s && bus.req_we && !fault_s) begin
      for (int l = 0; l < 4; l++) begin
        if (be_s[l]) begin
          mem[mem_idx_s][8*l +: 8] <= wlane_s[8*l +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule
